// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and size/alignment helpers for the load/store sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

  // Access size in bytes; 0 marks an encoding that is never legal.
  function automatic logic [2:0] fn3_size(input logic [2:0] fn3);
    case (fn3)
      FN3_LB, FN3_LBU: fn3_size = 3'd1;
      FN3_LH, FN3_LHU: fn3_size = 3'd2;
      FN3_LW:          fn3_size = 3'd4;
      default:         fn3_size = 3'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] fn3, input logic [1:0] addr_lo);
    logic [2:0] size;
    size = fn3_size(fn3);
    is_misaligned = ((size == 3'd2) && addr_lo[0]) || ((size == 3'd4) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load-data extension: selects and sign/zero-extends raw memory data by funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_fn3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = 32'h0;
    case (i_fn3)
      FN3_LB:  o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      FN3_LH:  o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      FN3_LW:  o_data = i_raw;
      FN3_LBU: o_data = {24'h0, i_raw[7:0]};
      FN3_LHU: o_data = {16'h0, i_raw[15:0]};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between MEM stage and byte-addressed data memory; misaligned
// halfword/word accesses are optionally split into byte accesses.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h8000_2000,
  parameter int unsigned MEM_BYTES        = 16384,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_fn3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wr_en,
  output logic [2:0]  o_mem_fn3,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [32:0] LastAddr = {1'b0, BASE_ADDR} + 33'(MEM_BYTES) - 33'd1;

  lsu_state_e  r_state, w_state_d;
  logic        r_store, r_mis, r_err;
  logic [2:0]  r_fn3, r_size;
  logic [31:0] r_addr, r_wdata, r_asm;
  logic [1:0]  r_cnt;
  logic        r_resp_valid, r_resp_err;
  logic [31:0] r_resp_rdata;

  logic [2:0]  w_req_size;
  logic        w_req_illegal, w_req_mis, w_req_range_err, w_req_err;
  logic [32:0] w_req_last;
  logic        w_last_byte;
  logic [7:0]  w_wbyte;
  logic [31:0] w_ext_data;

  assign w_req_size    = fn3_size(i_req_fn3);
  assign w_req_illegal = (w_req_size == 3'd0) || (i_req_store && i_req_fn3[2]);
  assign w_req_mis     = is_misaligned(i_req_fn3, i_req_addr[1:0]);
  // 33-bit compare so an access straddling 2^32 cannot wrap back into the window.
  assign w_req_last      = {1'b0, i_req_addr} + {30'h0, w_req_size} - 33'd1;
  assign w_req_range_err = (i_req_addr < BASE_ADDR) || (w_req_last > LastAddr);
  assign w_req_err       = w_req_illegal || w_req_range_err || (w_req_mis && !SPLIT_MISALIGNED);

  assign w_last_byte = ({1'b0, r_cnt} == (r_size - 3'd1));
  assign w_wbyte     = r_wdata[{r_cnt, 3'b000} +: 8];

  lsu_load_extend u_load_extend (
    .i_fn3  (r_fn3),
    .i_raw  (r_asm),
    .o_data (w_ext_data)
  );

  always_comb begin
    w_state_d   = r_state;
    o_req_ready = 1'b0;
    o_mem_addr  = r_addr;
    o_mem_wdata = r_wdata;
    o_mem_wr_en = 1'b0;
    o_mem_fn3   = FN3_LBU;
    unique case (r_state)
      StIdle: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_state_d = w_req_err ? StResp : StAccess;
        end
      end
      StAccess: begin
        o_mem_wr_en = r_store;
        if (r_mis) begin
          o_mem_addr  = r_addr + {30'h0, r_cnt};
          o_mem_fn3   = r_store ? FN3_SB : FN3_LBU;
          o_mem_wdata = {24'h0, w_wbyte};
          if (w_last_byte) begin
            w_state_d = StResp;
          end
        end else begin
          o_mem_fn3 = r_fn3;
          w_state_d = StResp;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_store      <= 1'b0;
      r_mis        <= 1'b0;
      r_err        <= 1'b0;
      r_fn3        <= 3'h0;
      r_size       <= 3'h0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_asm        <= 32'h0;
      r_cnt        <= 2'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_state      <= w_state_d;
      r_resp_valid <= (r_state == StResp);
      case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_store <= i_req_store;
            r_fn3   <= i_req_fn3;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_size  <= w_req_size;
            r_mis   <= w_req_mis;
            r_err   <= w_req_err;
            r_cnt   <= 2'h0;
            r_asm   <= 32'h0;
          end
        end
        StAccess: begin
          if (r_mis) begin
            if (!r_store) begin
              r_asm[{r_cnt, 3'b000} +: 8] <= i_mem_rdata[7:0];
            end
            r_cnt <= r_cnt + 2'd1;
          end else if (!r_store) begin
            r_asm <= i_mem_rdata;
          end
        end
        StResp: begin
          r_resp_err   <= r_err;
          r_resp_rdata <= (r_store || r_err) ? 32'h0 : w_ext_data;
        end
        default: ;
      endcase
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench: directed and random load/store traffic against a byte-array reference.
module tb_lsu_mem_sequencer;

  localparam logic [31:0] BASE   = 32'h8000_2000;
  localparam int unsigned MEMB   = 16384;
  localparam logic [31:0] MEMB32 = 32'd16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_valid2 = 1'b0, req_store = 1'b0;
  logic [2:0]  req_fn3 = 3'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

  logic        req_ready, resp_valid, resp_err, mem_wr_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_fn3;

  logic        req_ready2, resp_valid2, resp_err2, mem_wr_en2;
  logic [31:0] resp_rdata2, mem_addr2, mem_wdata2;
  logic [2:0]  mem_fn32;
  logic [31:0] mem_rdata2 = 32'hCAFE_F00D;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [MEMB];
  logic [7:0]  ref_mem [MEMB];
  bit          mem_init_done = 1'b0;
  logic [31:0] ma [4];
  logic [7:0]  rb [4];
  int          wr_bytes;

  lsu_mem_sequencer #(
    .BASE_ADDR        (BASE),
    .MEM_BYTES        (MEMB),
    .SPLIT_MISALIGNED (1'b1)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_store  (req_store),
    .i_req_fn3    (req_fn3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wr_en  (mem_wr_en),
    .o_mem_fn3    (mem_fn3),
    .i_mem_rdata  (mem_rdata)
  );

  lsu_mem_sequencer #(
    .BASE_ADDR        (BASE),
    .MEM_BYTES        (MEMB),
    .SPLIT_MISALIGNED (1'b0)
  ) u_dut2 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid2),
    .o_req_ready  (req_ready2),
    .i_req_store  (req_store),
    .i_req_fn3    (req_fn3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid2),
    .o_resp_rdata (resp_rdata2),
    .o_resp_err   (resp_err2),
    .o_mem_addr   (mem_addr2),
    .o_mem_wdata  (mem_wdata2),
    .o_mem_wr_en  (mem_wr_en2),
    .o_mem_fn3    (mem_fn32),
    .i_mem_rdata  (mem_rdata2)
  );

  // Behavioural data memory: combinational read, write on negedge.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ma[k] = mem_addr - BASE + 32'(k);
      rb[k] = (ma[k] < MEMB32) ? mem[ma[k][13:0]] : 8'h00;
    end
    wr_bytes = (mem_fn3[1:0] == 2'd0) ? 1 : (mem_fn3[1:0] == 2'd1) ? 2 : 4;
    mem_rdata = 32'h0;
    case (mem_fn3)
      3'b000:  mem_rdata = {{24{rb[0][7]}}, rb[0]};
      3'b001:  mem_rdata = {{16{rb[1][7]}}, rb[1], rb[0]};
      3'b010:  mem_rdata = {rb[3], rb[2], rb[1], rb[0]};
      3'b100:  mem_rdata = {24'h0, rb[0]};
      3'b101:  mem_rdata = {16'h0, rb[1], rb[0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEMB; i++) mem[i] <= 8'h00;
      mem_init_done <= 1'b1;
    end else if (mem_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (k < wr_bytes && ma[k] < MEMB32) mem[ma[k][13:0]] <= mem_wdata[8*k +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: outcome of one request derived from the access rules, updating ref_mem.
  task automatic ref_op(input bit split, input logic st, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] exp_d, output logic exp_e,
                        output int exp_lat, output int exp_wr);
    int     size, off;
    longint lo, v;
    bit     bad, mis;
    case (f)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    lo  = longint'({32'h0, a});
    bad = (size == 0) || (st && f >= 3'd4);
    bad = bad || (lo < longint'({32'h0, BASE}))
              || (lo + size - 1 > longint'({32'h0, BASE}) + longint'(MEMB) - 1);
    mis = (size != 0) && ((lo % size) != 0);
    if (mis && !split) bad = 1'b1;
    exp_e   = bad;
    exp_d   = 32'h0;
    exp_wr  = 0;
    exp_lat = bad ? 1 : (mis ? size + 1 : 2);
    if (!bad) begin
      off = int'(lo - longint'({32'h0, BASE}));
      if (st) begin
        for (int k = 0; k < size; k++) ref_mem[off + k] = wd[8*k +: 8];
        exp_wr = mis ? size : 1;
      end else begin
        v = 0;
        for (int k = 0; k < size; k++) v = v + (longint'(ref_mem[off + k]) << (8 * k));
        if (f == 3'd0 && v >= 128)   v = v - 256;
        if (f == 3'd1 && v >= 32768) v = v - 65536;
        exp_d = v[31:0];
      end
    end
  endtask

  task automatic do_req(input bit d2, input logic st, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] ed;
    logic        ee;
    int          el, ew, lat, wr;
    bit          got, busy_ok;
    ref_op(!d2, st, f, a, wd, ed, ee, el, ew);
    check({tag, "_ready"}, {31'h0, d2 ? req_ready2 : req_ready}, 32'h1);
    req_store = st;
    req_fn3   = f;
    req_addr  = a;
    req_wdata = wd;
    if (d2) req_valid2 = 1'b1;
    else    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
    lat = 0; wr = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && lat < 16) begin
      if (d2 ? resp_valid2 : resp_valid) begin
        got = 1'b1;
      end else begin
        if (d2 ? mem_wr_en2 : mem_wr_en) wr++;
        if (d2 ? req_ready2 : req_ready) busy_ok = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, "_lat"},   32'(lat), 32'(el));
    check({tag, "_err"},   {31'h0, d2 ? resp_err2 : resp_err}, {31'h0, ee});
    check({tag, "_rdata"}, d2 ? resp_rdata2 : resp_rdata, ed);
    check({tag, "_wrcyc"}, 32'(wr), 32'(ew));
    check({tag, "_busy"},  {31'h0, busy_ok}, 32'h1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'h0, d2 ? resp_valid2 : resp_valid}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    int         nresp;
    logic [31:0] held_rdata;
    logic [2:0] fsel;
    logic [31:0] ra;
    logic [2:0] legal [5];
    legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {31'h0, req_ready},  32'h1);
    check("rst_rvalid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata",  resp_rdata,          32'h0);
    check("rst_err",    {31'h0, resp_err},   32'h0);
    check("rst_wren",   {31'h0, mem_wr_en},  32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: aligned word, misaligned word, byte/half extension.
    do_req(1'b0, 1'b1, 3'd2, BASE,     32'hDEAD_BEEF, "sw_al");
    do_req(1'b0, 1'b0, 3'd2, BASE,     32'h0,         "lw_al");
    do_req(1'b0, 1'b1, 3'd2, BASE + 1, 32'h1122_3344, "sw_mis");
    check("mem_b0", {24'h0, mem[0]}, 32'hEF);
    check("mem_b1", {24'h0, mem[1]}, 32'h44);
    check("mem_b2", {24'h0, mem[2]}, 32'h33);
    check("mem_b3", {24'h0, mem[3]}, 32'h22);
    check("mem_b4", {24'h0, mem[4]}, 32'h11);
    do_req(1'b0, 1'b0, 3'd2, BASE + 1, 32'h0,         "lw_mis");
    do_req(1'b0, 1'b1, 3'd0, BASE + 3, 32'h0000_0080, "sb");
    do_req(1'b0, 1'b0, 3'd0, BASE + 3, 32'h0,         "lb");
    do_req(1'b0, 1'b0, 3'd4, BASE + 3, 32'h0,         "lbu");
    do_req(1'b0, 1'b1, 3'd1, BASE + 5, 32'h0000_8001, "sh_mis");
    do_req(1'b0, 1'b0, 3'd1, BASE + 5, 32'h0,         "lh_mis");
    do_req(1'b0, 1'b0, 3'd5, BASE + 5, 32'h0,         "lhu_mis");

    // Window boundaries and illegal encodings.
    do_req(1'b0, 1'b0, 3'd2, 32'h8000_1FFC, 32'h0,    "lw_below");
    do_req(1'b0, 1'b0, 3'd2, 32'h8000_5FFE, 32'h0,    "lw_above");
    do_req(1'b0, 1'b1, 3'd2, 32'h8000_5FFE, 32'h5555_5555, "sw_above");
    do_req(1'b0, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0,    "lw_wrap");
    do_req(1'b0, 1'b1, 3'd2, 32'h8000_5FFC, 32'hA5A5_0F0F, "sw_top");
    do_req(1'b0, 1'b0, 3'd2, 32'h8000_5FFC, 32'h0,    "lw_top");
    do_req(1'b0, 1'b0, 3'd3, BASE,          32'h0,    "ld_fn3_011");
    do_req(1'b0, 1'b1, 3'd4, BASE,          32'h0,    "st_fn3_100");

    // Non-splitting instance.
    do_req(1'b1, 1'b0, 3'd1, BASE + 1, 32'h0, "ns_lh_mis");
    do_req(1'b1, 1'b0, 3'd3, BASE,     32'h0, "ns_fn3_011");
    req_store  = 1'b0;
    req_fn3    = 3'd2;
    req_addr   = BASE;
    req_valid2 = 1'b1;
    pat = 6'h0; nresp = 0; held_rdata = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat = {pat[4:0], req_ready2};
      if (resp_valid2) begin
        nresp++;
        held_rdata = resp_rdata2;
      end
    end
    req_valid2 = 1'b0;
    check("ns_hold_ready", {26'h0, pat}, 32'h0000_0024);
    check("ns_hold_nresp", 32'(nresp),   32'h1);
    check("ns_hold_rdata", held_rdata,   32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = BASE + MEMB32 - 32'($urandom_range(1, 4));
        1:       ra = BASE - 32'($urandom_range(1, 4));
        default: ra = BASE + 32'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 7) == 0) fsel = 3'($urandom_range(0, 7));
      else                           fsel = legal[$urandom_range(0, 4)];
      do_req(1'b0, 1'($urandom_range(0, 1)), fsel, ra, $urandom, "rnd");
    end

    // Reset during byte 2 of a misaligned store.
    req_store = 1'b1;
    req_fn3   = 3'd2;
    req_addr  = BASE + 32'h101;
    req_wdata = 32'hA1B2_C3D4;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ra_b0_addr", mem_addr, BASE + 32'h101);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ra_b2_wren", {31'h0, mem_wr_en}, 32'h1);
    check("ra_b2_addr", mem_addr, BASE + 32'h103);
    rst_n = 1'b0;
    #1;
    check("ra_wr_drop", {31'h0, mem_wr_en}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ra_ready",  {31'h0, req_ready},  32'h1);
    check("ra_rvalid", {31'h0, resp_valid}, 32'h0);
    ref_mem[32'h101] = 8'hD4;
    ref_mem[32'h102] = 8'hC3;
    for (int k = 1; k <= 4; k++) begin
      check("ra_mem", {24'h0, mem[32'h100 + k]}, {24'h0, ref_mem[32'h100 + k]});
    end
    do_req(1'b0, 1'b0, 3'd2, BASE + 32'h101, 32'h0, "ra_lw");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
